// File: rtl/ring_seq_pkg.sv
// Shared types and constants for the ring scene sequencer: FSM states,
// scene count and phase step sizes.
package ring_seq_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    TRANS = 1'b1
  } state_t;

  localparam int NUM_SCENES = 4;
  localparam int SCENE_W    = $clog2(NUM_SCENES);

  localparam logic [1:0] STEP_SLOW = 2'd1;
  localparam logic [1:0] STEP_FAST = 2'd2;

  function automatic logic [SCENE_W-1:0] next_scene(input logic [SCENE_W-1:0] s);
    return (int'(s) == NUM_SCENES - 1) ? '0 : s + SCENE_W'(1);
  endfunction

endpackage

// File: rtl/ring_scene_sequencer_btn_debounce.sv
// Pushbutton conditioning: 2-flop synchronizer, frame-rate debounce and a
// single-cycle press pulse on each accepted 0->1 level change.
module btn_debounce #(
  parameter int DEB_FRAMES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic frame_start,
  input  logic btn,
  output logic press
);

  localparam logic [3:0] DEB_LAST = 4'(DEB_FRAMES - 1);

  logic       sync_a;
  logic       sync_b;
  logic       level;
  logic [3:0] cnt;

  // cnt counts consecutive frame samples that disagree with the accepted level
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      level  <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync_a <= btn;
      sync_b <= sync_a;
      press  <= 1'b0;
      if (frame_start) begin
        if (sync_b == level) begin
          cnt <= '0;
        end else if (cnt == DEB_LAST) begin
          level <= sync_b;
          cnt   <= '0;
          press <= sync_b;
        end else begin
          cnt <= cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/ring_scene_sequencer.sv
// Frame-synchronous scene sequencer for the ring animation: advances the
// animation phase, and fades between scenes on a button press or dwell timeout.
module ring_scene_sequencer
  import ring_seq_pkg::*;
#(
  parameter int DWELL_FRAMES = 240,
  parameter int DEB_FRAMES   = 4,
  parameter int FADE_FRAMES  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_start,
  input  logic       btn_next,
  input  logic       auto_en,
  input  logic       pause,
  input  logic       speed,
  input  logic       dir_sw,
  output logic [7:0] anim_offset,
  output logic       direction,
  output logic [1:0] scene,
  output logic [1:0] dim,
  output logic       busy
);

  localparam int                FADE_W     = $clog2(FADE_FRAMES);
  localparam logic [FADE_W-1:0] FADE_LAST  = FADE_W'(FADE_FRAMES - 1);
  localparam logic [8:0]        DWELL_LAST = 9'(DWELL_FRAMES - 1);

  state_t             state;
  state_t             state_next;
  logic [9:0]         phase;
  logic [8:0]         dwell;
  logic [FADE_W-1:0]  fade_cnt;
  logic [SCENE_W-1:0] scene_q;
  logic [1:0]         step;
  logic               next_req;
  logic               auto_req;
  logic               adv_req;
  logic               fade_done;

  btn_debounce #(
    .DEB_FRAMES(DEB_FRAMES)
  ) u_btn (
    .clk        (clk),
    .reset      (reset),
    .frame_start(frame_start),
    .btn        (btn_next),
    .press      (next_req)
  );

  assign step      = speed ? STEP_FAST : STEP_SLOW;
  assign auto_req  = auto_en && !pause && frame_start && (state == RUN) && (dwell == DWELL_LAST);
  assign adv_req   = next_req || auto_req;
  assign fade_done = frame_start && (fade_cnt == FADE_LAST);

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  // Requests arriving while a fade is running are simply dropped.
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (adv_req)   state_next = TRANS;
      TRANS:   if (fade_done) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    dim  = 2'd0;
    if (state == TRANS) begin
      busy = 1'b1;
      dim  = fade_cnt[FADE_W-1 -: 2];
    end
  end

  // A frame that also triggers a transition still advances phase; dwell then clears.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase    <= '0;
      dwell    <= '0;
      fade_cnt <= '0;
      scene_q  <= '0;
    end else begin
      case (state)
        RUN: begin
          if (frame_start && !pause) begin
            phase <= phase + {8'd0, step};
            if (auto_en) dwell <= dwell + 9'd1;
          end
          if (adv_req) begin
            dwell    <= '0;
            fade_cnt <= '0;
          end
        end
        TRANS: begin
          if (fade_done) begin
            fade_cnt <= '0;
            dwell    <= '0;
            scene_q  <= next_scene(scene_q);
          end else if (frame_start) begin
            fade_cnt <= fade_cnt + FADE_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign anim_offset = {phase[6:0], 1'b0};
  assign scene       = scene_q;
  assign direction   = dir_sw ^ scene_q[0];

endmodule

// File: tb/tb_ring_scene_sequencer.sv
// Self-checking bench for ring_scene_sequencer: frame-level reference model
// feeding an expected queue, table-driven phase vectors and hand-written
// sequences for button, auto-advance and reset corner cases.
module tb_ring_scene_sequencer;

  localparam int DWELL = 240;
  localparam int DEB   = 4;
  localparam int FADE  = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_start;
  logic       btn_next;
  logic       auto_en;
  logic       pause;
  logic       speed;
  logic       dir_sw;
  logic [7:0] anim_offset;
  logic       direction;
  logic [1:0] scene;
  logic [1:0] dim;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [13:0] exp_q[$];

  logic [9:0] m_phase;
  logic [8:0] m_dwell;
  logic [3:0] m_fade;
  logic [1:0] m_scene;
  logic       m_trans;
  logic       m_lvl;
  int         m_dcnt;

  typedef struct {
    logic       rst;
    logic       spd;
    logic       pse;
    int         frames;
    logic [7:0] off;
  } vec_t;

  vec_t vecs[7];

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  ring_scene_sequencer #(
    .DWELL_FRAMES(DWELL),
    .DEB_FRAMES  (DEB),
    .FADE_FRAMES (FADE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_start(frame_start),
    .btn_next   (btn_next),
    .auto_en    (auto_en),
    .pause      (pause),
    .speed      (speed),
    .dir_sw     (dir_sw),
    .anim_offset(anim_offset),
    .direction  (direction),
    .scene      (scene),
    .dim        (dim),
    .busy       (busy)
  );

  // ---------------- reference model ----------------
  function automatic logic [13:0] model_out();
    logic [1:0] d;
    d = m_trans ? m_fade[3:2] : 2'd0;
    return {m_phase[6:0], 1'b0, m_scene, d, m_trans, dir_sw ^ m_scene[0]};
  endfunction

  task automatic model_reset();
    m_phase = '0;
    m_dwell = '0;
    m_fade  = '0;
    m_scene = '0;
    m_trans = 1'b0;
    m_lvl   = 1'b0;
    m_dcnt  = 0;
  endtask

  task automatic model_frame(input logic b);
    logic rise;
    logic fire;
    rise = 1'b0;
    if (b == m_lvl) begin
      m_dcnt = 0;
    end else if (m_dcnt == DEB - 1) begin
      m_lvl  = b;
      m_dcnt = 0;
      rise   = b;
    end else begin
      m_dcnt++;
    end
    if (!m_trans) begin
      fire = auto_en && !pause && (m_dwell == 9'(DWELL - 1));
      if (!pause) begin
        m_phase = m_phase + (speed ? 10'd2 : 10'd1);
        if (auto_en) m_dwell = m_dwell + 9'd1;
      end
      if (fire) begin
        m_trans = 1'b1;
        m_dwell = '0;
        m_fade  = '0;
      end
    end else if (m_fade == 4'(FADE - 1)) begin
      m_fade  = '0;
      m_dwell = '0;
      m_scene = m_scene + 2'd1;
      m_trans = 1'b0;
    end else begin
      m_fade = m_fade + 4'd1;
    end
    // the debounced press lands the cycle after the frame edge
    if (!m_trans && rise) begin
      m_trans = 1'b1;
      m_dwell = '0;
      m_fade  = '0;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_out(input string name);
    logic [13:0] exp_v;
    logic [13:0] act_v;
    act_v = {anim_offset, scene, dim, busy, direction};
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: expected queue empty, got %h", name, act_v);
    end else begin
      exp_v = exp_q.pop_front();
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL %s: got %h (off,scene,dim,busy,dir) want %h at %0t", name, act_v, exp_v, $time);
      end
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic do_reset();
    @(negedge clk);
    reset       = 1'b1;
    frame_start = 1'b0;
    btn_next    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    exp_q.push_back(model_out());
    check_out("reset");
  endtask

  // Four clocks per frame: button settles through the synchronizer before the pulse.
  task automatic do_frame(input logic b);
    btn_next = b;
    dir_sw   = 1'($urandom_range(0, 1));
    @(negedge clk);
    @(negedge clk);
    frame_start = 1'b1;
    model_frame(b);
    exp_q.push_back(model_out());
    @(negedge clk);
    frame_start = 1'b0;
    @(negedge clk);
    check_out("frame");
  endtask

  task automatic auto_cycle(input int exp_scene);
    int n;
    n = 0;
    do begin
      do_frame(1'b0);
      n++;
    end while (!busy && n < 300);
    check_val("dwell_len", n, DWELL);
    check_val("dim_walk", int'(dim), 0);
    for (int k = 1; k < FADE; k++) begin
      do_frame(1'b0);
      check_val("dim_walk", int'(dim), k / 4);
    end
    do_frame(1'b0);
    check_val("fade_end_busy", int'(busy), 0);
    check_val("scene_seq", int'(scene), exp_scene);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main test ----------------
  initial begin
    int n;
    int trans_cnt;
    logic prev_busy;
    logic b;
    int scene_exp[4];

    reset       = 1'b1;
    frame_start = 1'b0;
    btn_next    = 1'b0;
    auto_en     = 1'b0;
    pause       = 1'b0;
    speed       = 1'b0;
    dir_sw      = 1'b0;
    model_reset();

    vecs[0] = '{rst: 1'b1, spd: 1'b0, pse: 1'b0, frames: 10,  off: 8'h14};
    vecs[1] = '{rst: 1'b0, spd: 1'b1, pse: 1'b1, frames: 5,   off: 8'h14};
    vecs[2] = '{rst: 1'b1, spd: 1'b1, pse: 1'b0, frames: 600, off: 8'h60};
    vecs[3] = '{rst: 1'b0, spd: 1'b0, pse: 1'b0, frames: 3,   off: 8'h66};
    vecs[4] = '{rst: 1'b0, spd: 1'b1, pse: 1'b1, frames: 7,   off: 8'h66};
    vecs[5] = '{rst: 1'b0, spd: 1'b1, pse: 1'b0, frames: 38,  off: 8'hFE};
    vecs[6] = '{rst: 1'b0, spd: 1'b0, pse: 1'b0, frames: 1,   off: 8'h00};
    scene_exp = '{1, 2, 3, 0};

    // phase progression, pause and wrap
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].rst) do_reset();
      speed = vecs[i].spd;
      pause = vecs[i].pse;
      repeat (vecs[i].frames) do_frame(1'b0);
      check_val("vec_offset", int'(anim_offset), int'(vecs[i].off));
      check_val("vec_scene", int'(scene), 0);
      check_val("vec_dim", int'(dim), 0);
    end
    speed = 1'b0;
    pause = 1'b0;

    // short press is rejected, long press gives exactly one transition
    do_reset();
    repeat (2) do_frame(1'b1);
    repeat (3) do_frame(1'b0);
    check_val("short_press", int'(busy), 0);
    repeat (3) do_frame(1'b1);
    check_val("press_pre", int'(busy), 0);
    do_frame(1'b1);
    check_val("press_accept", int'(busy), 1);
    n = 1;
    for (int k = 0; k < 40 && busy; k++) begin
      do_frame(k < 2);
      if (busy) n++;
    end
    check_val("busy_len", n, FADE);
    check_val("scene_after_press", int'(scene), 1);
    repeat (10) do_frame(1'b0);
    check_val("no_extra_trans", int'(busy), 0);
    check_val("scene_hold", int'(scene), 1);

    // timed auto advance through all four scenes
    do_reset();
    auto_en = 1'b1;
    for (int c = 0; c < 4; c++) auto_cycle(scene_exp[c]);

    // coincident auto and manual request, then a press inside the fade
    do_reset();
    repeat (236) do_frame(1'b0);
    trans_cnt = 0;
    prev_busy = 1'b0;
    for (int k = 0; k < 50; k++) begin
      b = (k < 8) || (k >= 12 && k < 18);
      do_frame(b);
      if (busy && !prev_busy) trans_cnt++;
      prev_busy = busy;
    end
    check_val("single_advance", trans_cnt, 1);
    check_val("coincident_scene", int'(scene), 1);
    check_val("coincident_idle", int'(busy), 0);
    auto_en = 1'b0;

    // reset in the middle of a fade abandons it
    do_reset();
    repeat (4) do_frame(1'b1);
    repeat (9) do_frame(1'b0);
    check_val("mid_fade_dim", int'(dim), 2);
    check_val("mid_fade_busy", int'(busy), 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    exp_q.push_back(model_out());
    check_out("reset_mid_trans");
    check_val("abort_scene", int'(scene), 0);
    check_val("abort_busy", int'(busy), 0);
    check_val("abort_dim", int'(dim), 0);
    check_val("abort_dir", int'(direction), int'(dir_sw));
    repeat (5) do_frame(1'b0);
    check_val("abort_scene_hold", int'(scene), 0);

    check_val("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
